// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the BCD counters and the BCD-to-binary converter.
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Largest legal BCD digit value
  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_mul10_add.sv
// Combinational step of the MSD-first conversion: acc*10 + digit, with digit check.
module bcd_mul10_add
  import bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic [W-1:0] acc,
  input  bcd_digit_t   digit,
  output logic [W-1:0] result,
  output logic         digit_ok
);

  // acc*10 as (acc<<3)+(acc<<1). Carries only propagate upward, so computing
  // modulo 2^W gives exactly the low W bits of the widened sum; an invalid
  // digit contributes nothing.
  always_comb begin
    digit_ok = (digit <= BCD_MAX);
    result   = (acc << 3) + (acc << 1) + (digit_ok ? W'(digit) : '0);
  end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Iterative packed-BCD to binary converter, one digit per clock, MSD first,
// with valid/ready handshakes on input and output and invalid-digit detection.
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int BIN_W  = $clog2(10**DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err_out
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state;
  state_t            state_next;
  logic [SR_W-1:0]   digit_sr;
  logic [BIN_W-1:0]  acc;
  logic              err;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  bin_q;
  logic              err_q;

  logic [BIN_W-1:0]  acc_step;
  logic              digit_ok;
  logic              err_step;
  logic              accept;
  logic              release_out;
  logic              last_digit;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_digit  = (state == CONV) && (cnt == '0);
  assign err_step    = err | ~digit_ok;

  bcd_mul10_add #(
    .W (BIN_W)
  ) u_mul10_add (
    .acc      (acc),
    .digit    (digit_sr[SR_W-1 -: 4]),
    .result   (acc_step),
    .digit_ok (digit_ok)
  );

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)      state_next = CONV;
      CONV:    if (last_digit)  state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: digit shift register, accumulator, sticky error, counter, result regs
  // NOTE: every datapath register is reset so an aborted conversion leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sr <= '0;
      acc      <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            digit_sr <= bcd_in;
            acc      <= '0;
            err      <= 1'b0;
            cnt      <= CNT_W'(DIGITS - 1);
          end
        end
        CONV: begin
          acc      <= acc_step;
          err      <= err_step;
          digit_sr <= digit_sr << 4;
          if (last_digit) begin
            // Result is published only on the edge entering DONE
            bin_q <= err_step ? '0 : acc_step;
            err_q <= err_step;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (release_out) begin
            bin_q <= '0;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_out = bin_q;
  assign err_out = err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Directed self-checking bench for bcd_to_bin_converter (DIGITS = 4).
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err_out;

  int vectors;
  int miscompares;
  int cyc;

  bcd_to_bin_converter #(
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Present a word and hold in_valid until it is accepted (bounded wait).
  // Returns with time at #1 after the accept edge, in_valid dropped.
  task automatic send_word(input logic [15:0] w, input string name);
    int n;
    n = 0;
    bcd_in   = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept_timeout: in_ready=%b required 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full transaction with out_ready high: latency, value, error and one-cycle pulse.
  task automatic run_word(input logic [15:0] w, input logic [BIN_W-1:0] exp_bin,
                          input logic exp_err, input string name);
    int n;
    send_word(w, name);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n !== DIGITS) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, DIGITS);
    end
    vectors++;
    if (bin_out !== exp_bin) begin
      miscompares++;
      $display("FAIL %s bin_out: got %0d required %0d", name, bin_out, exp_bin);
    end
    vectors++;
    if (err_out !== exp_err) begin
      miscompares++;
      $display("FAIL %s err_out: got %b required %b", name, err_out, exp_err);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || bin_out !== '0 || err_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse_end: out_valid=%b bin_out=%0d err_out=%b required 0/0/0",
               name, out_valid, bin_out, err_out);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    bcd_in    = 16'h1234;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== '0 || err_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b bin_out=%0d err_out=%b required 1/0/0/0",
               in_ready, out_valid, bin_out, err_out);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    run_word(16'h1234, 14'd1234, 1'b0, "basic_1234");
  endtask

  task automatic test_extremes();
    run_word(16'h9999, 14'd9999, 1'b0, "max_9999");
    run_word(16'h0000, 14'd0,    1'b0, "zero_0000");
  endtask

  task automatic test_invalid_digit();
    run_word(16'h12A4, 14'd0, 1'b1, "invalid_12A4");
    run_word(16'h0007, 14'd7, 1'b0, "after_err_0007");
    run_word(16'hF000, 14'd0, 1'b1, "invalid_msd_F000");
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    send_word(16'h0500, "bp_0500");
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bcd_in   = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || bin_out !== 14'd500 || err_out !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: out_valid=%b bin_out=%0d err_out=%b in_ready=%b required 1/500/0/0",
                 i, out_valid, bin_out, err_out, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept_after: in_ready=%b required 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1 || bin_out !== 14'd1 || err_out !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_queued_word: out_valid=%b bin_out=%0d err_out=%b required 1/1/0",
               out_valid, bin_out, err_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_conv();
    send_word(16'h8765, "midrst_8765");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== '0) begin
        miscompares++;
        $display("FAIL midrst_no_result[%0d]: out_valid=%b in_ready=%b bin_out=%0d required 0/1/0",
                 i, out_valid, in_ready, bin_out);
      end
    end
    run_word(16'h0042, 14'd42, 1'b0, "midrst_0042");
  endtask

  task automatic test_back_to_back();
    logic [15:0]      words [3];
    logic [BIN_W-1:0] exp   [3];
    int acc_cyc [3];
    int w_idx;
    int r_idx;
    int n;
    logic pre_acc;
    words = '{16'h0314, 16'h2718, 16'h0001};
    exp   = '{14'd314, 14'd2718, 14'd1};
    w_idx = 0;
    r_idx = 0;
    n     = 0;
    out_ready = 1'b1;
    bcd_in    = words[0];
    in_valid  = 1'b1;
    while (r_idx < 3 && n < 60) begin
      pre_acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (pre_acc) begin
        acc_cyc[w_idx] = cyc;
        w_idx++;
        if (w_idx < 3) bcd_in = words[w_idx];
        else           in_valid = 1'b0;
      end
      if (out_valid) begin
        vectors++;
        if (bin_out !== exp[r_idx] || err_out !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: bin_out=%0d err_out=%b required %0d/0",
                   r_idx, bin_out, err_out, exp[r_idx]);
        end
        r_idx++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (r_idx !== 3 || w_idx !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: accepts=%0d results=%0d required 3/3", w_idx, r_idx);
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (acc_cyc[i] - acc_cyc[i-1] !== DIGITS + 2) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                   i, acc_cyc[i] - acc_cyc[i-1], DIGITS + 2);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    bcd_in      = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_invalid_digit();
    test_backpressure();
    test_reset_mid_conv();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
